// File: rtl/aes_key_expander.sv
// AES-128 key-schedule controller driving a single-round keygeneration stage; round keys kept in a register file.
// Define AES_KEYEXP_REVERSE_RD_EN to read the register file in decryption order (index 0 = last round key).

module keygeneration (
    input  logic         start,
    input  logic [3:0]   rc,
    input  logic [127:0] key,
    output logic         finished,
    output logic [127:0] keyout
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (exponent bits 7..1 set), then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] pw;
        logic [7:0] inv;
        acc = 8'h01;
        pw  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) acc = gmul(acc, pw);
            pw = gmul(pw, pw);
        end
        inv = acc;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0   = key[127:96];
        w1   = key[95:64];
        w2   = key[63:32];
        w3   = key[31:0];
        // RotWord then SubWord on the last word, rcon folded into the top byte.
        temp = {sbox(w3[23:16]) ^ rcon(rc), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
    end

    assign keyout   = {n0, n1, n2, n3};
    assign finished = start;

endmodule

module aes_key_expander #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             rk_valid_o,
    input  logic [3:0]       rk_idx_i,
    output logic [KEY_W-1:0] rk_data_o
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, ROUND, GAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       r;
    logic [3:0]       rc;
    logic             kg_start;
    logic             kg_finished;
    logic [KEY_W-1:0] kg_keyout;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] rk [0:NUM_ROUNDS];
    logic             accept;
    logic             kg_wr;

    assign rc     = r - 4'd1;
    assign accept = key_valid_i && key_ready_o && !rst;
    assign kg_wr  = (state == ROUND) && kg_finished && !rst;

    keygeneration u_keygen (
        .start    (kg_start),
        .rc       (rc),
        .key      (cur_key),
        .finished (kg_finished),
        .keyout   (kg_keyout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_valid_i) state_nxt = ROUND;
            ROUND:   if (kg_finished) state_nxt = GAP;
            GAP:     state_nxt = (r == LAST) ? DONE : ROUND;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
        kg_start    = (state == ROUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= 4'd0;
            rk_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                r          <= 4'd1;
                rk_valid_o <= 1'b0;
            end else if (state == GAP && r != LAST) begin
                r <= r + 4'd1;
            end else if (state == DONE) begin
                rk_valid_o <= 1'b1;
            end
        end
    end

    // Register file and feedback key carry no reset; validity is tracked by rk_valid_o.
    always_ff @(posedge clk) begin
        if (accept) begin
            rk[0]   <= key_i;
            cur_key <= key_i;
        end else if (kg_wr) begin
            rk[r]   <= kg_keyout;
            cur_key <= kg_keyout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_data_o <= '0;
        end else if (rk_idx_i <= LAST) begin
`ifdef AES_KEYEXP_REVERSE_RD_EN
            rk_data_o <= rk[LAST - rk_idx_i];
`else
            rk_data_o <= rk[rk_idx_i];
`endif
        end else begin
            rk_data_o <= '0;
        end
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Sequential AES-128 key-schedule controller placed directly upstream of the single-round `keygeneration` stage.
- Accepts a cipher key over a valid/ready handshake.
- Drives `keygeneration` once per round, feeding back each round key.
- Stores all NUM_ROUNDS+1 round keys in a register file.
- Round keys are read back through an indexed port by the cipher datapath.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; also sizes the register file (NUM_ROUNDS+1 entries).
- KEY_W, 128, key and round-key width. Only 128 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_i  in  KEY_W  cipher key; sampled on the handshake cycle.
- key_valid_i  in  1  key_i is valid.
- key_ready_o  out  1  block is able to accept a key.
- busy_o  out  1  expansion in progress.
- done_o  out  1  one-cycle pulse when the schedule is complete.
- rk_valid_o  out  1  the full schedule in the register file is valid.
- rk_idx_i  in  4  round-key read index.
- rk_data_o  out  KEY_W  round key, registered, 1-cycle read latency.

Behaviour:
- Reset values: key_ready_o=1, busy_o=0, done_o=0, rk_valid_o=0, rk_data_o=0. FSM goes to IDLE, round counter r=0. Register-file contents are don't-care.
- Internal instance of `keygeneration`:
  - Its start input is driven by the FSM signal kg_start.
  - rc = r-1 (4 bits).
  - key = cur_key register.
  - Its finished and keyout outputs are consumed by the FSM.
- FSM states and transitions:
  - IDLE: key_ready_o=1. On key_valid_i&&key_ready_o: RK[0]<=key_i, cur_key<=key_i, r<=1, rk_valid_o<=0, go to ROUND.
  - ROUND: kg_start=1, busy_o=1, key_ready_o=0. Stay in ROUND while finished==0. When finished==1: RK[r]<=keyout and cur_key<=keyout in that cycle, then go to GAP.
  - GAP: kg_start=0 for exactly one cycle, so the S-boxes see a fresh start edge. If r==NUM_ROUNDS go to DONE; otherwise r<=r+1 and go to ROUND.
  - DONE: done_o=1 and rk_valid_o<=1 for one cycle; go to IDLE.
- Latency: with finished returning in the first ROUND cycle, the accept-to-done_o distance is 2*NUM_ROUNDS+1 cycles (21 cycles).
- kg_start is 0 in IDLE, GAP and DONE.
- key_valid_i while busy: key_ready_o=0, key not consumed, no state effect. Keys are never queued.
- Read port: rk_data_o <= RK[rk_idx_i] every cycle.
  - Reads during expansion return the current register contents; rk_valid_o=0 signals that they are stale or partial.
  - rk_idx_i > NUM_ROUNDS returns 0.
- A new key accepted after DONE clears rk_valid_o on the accept cycle and overwrites RK[0..NUM_ROUNDS].
- rst asserted mid-expansion: FSM returns to IDLE next edge, rk_valid_o=0, no done_o pulse. Partial register contents remain readable but are flagged invalid.
- Simultaneous rst and key_valid_i: rst wins; the key is not accepted.

Optional Feature:
- Macro: AES_KEYEXP_REVERSE_RD_EN.
- Defined: read port addresses in decryption order, rk_data_o <= RK[NUM_ROUNDS - rk_idx_i]. Indices > NUM_ROUNDS return 0.
- Undefined: encryption order, rk_data_o <= RK[rk_idx_i].
- Expansion behaviour is identical in both builds.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_valid_i one cycle -> done_o pulses 21 cycles later. idx1 reads a0fafe1788542cb123a339392a6c7605. idx10 reads d014f9a8c9ee2589e13f0cc8b6630ca6. idx0 reads the key. rk_valid_o=1.
2. key_valid_i held high with a second key during expansion -> key_ready_o=0 throughout, second key ignored. Readback still equals scenario 1. Second key accepted only in the cycle after DONE.
3. rst asserted at cycle 8 after accept -> next cycle busy_o=0, key_ready_o=1, rk_valid_o=0, no done_o. A fresh key of all zeros then gives idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
4. rk_idx_i=11..15 after completion -> rk_data_o=0 one cycle later.
5. Build with AES_KEYEXP_REVERSE_RD_EN, FIPS key -> idx0 returns d014f9a8c9ee2589e13f0cc8b6630ca6 and idx10 returns 2b7e151628aed2a6abf7158809cf4f3c.
6. Back-to-back keys (FIPS, then all-zeros, accepted immediately after done_o) -> rk_valid_o drops on the second accept. After the second done_o, every index matches the all-zeros schedule.
